complex_mult_16: RTL and testbench



---
 rtl/complex_mult_16.sv | 55 +++++
 tb/tb_complex_mult_16.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_16.sv
// Three-stage signed fixed-point complex multiplier: product = data1 * data2.
// Each partial product is rounded half-up and truncated to 16 bits before the add/sub.
module complex_mult_16 #(
    parameter int I = 8,
    parameter int F = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic signed [15:0] data1   [0:1],
    input  logic signed [15:0] data2   [0:1],
    output logic signed [15:0] product [0:1]
);

    if (I + F != 16 || F < 1) begin : g_param_check
        $error("complex_mult_16: I + F must be 16 and F must be at least 1");
    end

    localparam logic signed [31:0] HALF = 32'sd1 <<< (F - 1);

    // The arithmetic shift plus 16-bit cast keeps bits [31-I:F] of the rounded product.
    function automatic logic signed [15:0] rnd_trunc(input logic signed [31:0] p);
        return 16'((p + HALF) >>> F);
    endfunction

    logic signed [15:0] a_r, b_r, c_r, d_r;
    logic signed [15:0] t_ac, t_bd, t_ad, t_bc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= '0;
            d_r        <= '0;
            t_ac       <= '0;
            t_bd       <= '0;
            t_ad       <= '0;
            t_bc       <= '0;
            product[0] <= '0;
            product[1] <= '0;
        end else if (en) begin
            a_r        <= data1[0];
            b_r        <= data1[1];
            c_r        <= data2[0];
            d_r        <= data2[1];
            t_ac       <= rnd_trunc(32'(a_r) * 32'(c_r));
            t_bd       <= rnd_trunc(32'(b_r) * 32'(d_r));
            t_ad       <= rnd_trunc(32'(a_r) * 32'(d_r));
            t_bc       <= rnd_trunc(32'(b_r) * 32'(c_r));
            product[0] <= t_ac - t_bd;
            product[1] <= t_ad + t_bc;
        end
    end

endmodule

// File: tb/tb_complex_mult_16.sv
// Randomised and directed scoreboard bench for complex_mult_16.
module tb_complex_mult_16;

    localparam int I = 8;
    localparam int F = 8;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } res_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic signed [15:0] data1   [0:1];
    logic signed [15:0] data2   [0:1];
    logic signed [15:0] product [0:1];

    complex_mult_16 #(.I(I), .F(F)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .data1   (data1),
        .data2   (data2),
        .product (product)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic in_valid   = 1'b0;
    logic finish_req = 1'b0;

    // Bench-side valid pipe with the same latency and enable as the datapath.
    logic [2:0] vp        = 3'b000;
    logic       en_at     = 1'b0;
    logic       rst_at    = 1'b1;
    logic       rst_prev  = 1'b1;
    logic       edge_seen = 1'b0;
    res_t       held;

    // floor((p + 2^(F-1)) / 2^F), wrapped to 16 bits
    function automatic logic signed [15:0] rt(input longint p);
        longint q;
        q = (p + (longint'(1) << (F - 1))) >>> F;
        return q[15:0];
    endfunction

    function automatic res_t ref_model(input int a, input int b, input int c, input int d);
        res_t r;
        r.re = rt(longint'(a) * longint'(c)) - rt(longint'(b) * longint'(d));
        r.im = rt(longint'(a) * longint'(d)) + rt(longint'(b) * longint'(c));
        return r;
    endfunction

    always @(posedge clk) begin
        edge_seen <= 1'b1;
        en_at     <= en;
        rst_at    <= reset;
        rst_prev  <= rst_at;
        if (!reset)  vp <= 3'b000;
        else if (en) vp <= {vp[1:0], in_valid};
    end

    always @(negedge clk) begin
        if (finish_req) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (edge_seen) begin
            if (!rst_at || !rst_prev) begin
                checks++;
                if (product[0] !== 16'sd0 || product[1] !== 16'sd0) begin
                    failures++;
                    $display("FAIL reset_zero: got {%0d,%0d} required {0,0}", product[0], product[1]);
                end
            end else if (!en_at) begin
                checks++;
                if (product[0] !== held.re || product[1] !== held.im) begin
                    failures++;
                    $display("FAIL stall_hold: got {%0d,%0d} required {%0d,%0d}",
                             product[0], product[1], held.re, held.im);
                end
            end else if (vp[2]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL underflow: got {%0d,%0d} with no pending expectation", product[0], product[1]);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if (product[0] !== e.re || product[1] !== e.im) begin
                        failures++;
                        $display("FAIL result: got {%0d,%0d} required {%0d,%0d}",
                                 product[0], product[1], e.re, e.im);
                    end
                end
            end
        end
        held.re = product[0];
        held.im = product[1];
    end

    task automatic issue(input int a, input int b, input int c, input int d);
        @(negedge clk);
        data1[0] = 16'(a);
        data1[1] = 16'(b);
        data2[0] = 16'(c);
        data2[1] = 16'(d);
        en       = 1'b1;
        in_valid = 1'b1;
        exp_q.push_back(ref_model(a, b, c, d));
    endtask

    task automatic idle(input int n, input logic en_val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            en       = en_val;
        end
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b1;
        data1[0] = 16'sd1234;
        data1[1] = -16'sd77;
        data2[0] = 16'sd3000;
        data2[1] = 16'sd999;
        repeat (4) @(negedge clk);
        reset    = 1'b1;
        data1[0] = '0;
        data1[1] = '0;
        data2[0] = '0;
        data2[1] = '0;
        idle(3, 1'b1);

        issue(256, 0, 1000, -500);
        issue(181, 181, 0, 256);
        issue(0, 256, 0, 256);
        issue(1, 0, 128, 0);
        issue(1, 0, 127, 0);
        issue(1, 0, -128, 0);
        issue(1, 0, -129, 0);
        issue(32767, 0, 32767, 0);
        idle(4, 1'b1);

        issue(300, -200, 1500, 700);
        issue(-1024, 512, -90, 33);
        issue(256, 256, 4000, -4000);
        issue(-32768, 100, 200, -32768);
        idle(3, 1'b0);
        issue(77, -77, 12345, -12345);
        issue(5, 6, 7, 8);
        idle(2, 1'b0);
        issue(-1, -1, -1, -1);
        idle(4, 1'b1);

        for (int n = 0; n < 120; n++) begin
            int  k;
            real th;
            k  = int'($urandom_range(0, 255));
            th = 2.0 * 3.14159265358979 * k / 256.0;
            issue($rtoi(256.0 * $cos(th)), $rtoi(256.0 * $sin(th)),
                  int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 32767)) - 16384);
            if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
        end

        idle(1, 1'b1);
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) idle(1, 1'b1);
        finish_req = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL finish: monitor did not close the run");
        $fatal(1);
    end

endmodule
